// File: rtl/mac_vlg_pkg.sv
// Shared MAC receive-path types: Ethernet header, buffer descriptor, read FSM states.
package mac_vlg_pkg;

   localparam logic [47:0] MAC_BCAST = 48'hffffffffffff;

   // Descriptor length field is wide enough for any byte RAM up to 64 KiB.
   localparam int LEN_W = 16;

   typedef struct packed {
      logic [47:0] dst_mac;
      logic [47:0] src_mac;
      logic [15:0] ethertype;
   } hdr_t;

   typedef struct packed {
      logic [LEN_W-1:0] len;
      hdr_t             hdr;
   } desc_t;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_LOAD,
      RD_SEND
   } rd_state_t;

   // A frame is accepted when addressed to us or to broadcast.
   function automatic logic dst_accepted(hdr_t h, logic [47:0] own);
      return (h.dst_mac == own) || (h.dst_mac == MAC_BCAST);
   endfunction

endpackage

// File: rtl/mac_vlg_rx_buf_if.sv
// Byte-stream bundle between the MAC receiver, the receive buffer and its consumer.
interface mac_vlg_rx_buf_if import mac_vlg_pkg::*; #(
   parameter int ADDR_W = 11
) ();

   logic [7:0]        in_dat;
   logic              in_val;
   logic              in_sof;
   logic              in_eof;
   logic              in_err;
   hdr_t              in_hdr;
   logic [47:0]       mac_addr;
   logic              out_rdy;

   logic [7:0]        out_dat;
   logic              out_val;
   logic              out_sof;
   logic              out_eof;
   logic [ADDR_W-1:0] out_len;
   hdr_t              out_hdr;
   logic              drp_err;
   logic              drp_ovf;
   logic              drp_flt;

   modport master (
      output in_dat, in_val, in_sof, in_eof, in_err, in_hdr, mac_addr, out_rdy,
      input  out_dat, out_val, out_sof, out_eof, out_len, out_hdr,
      input  drp_err, drp_ovf, drp_flt
   );

   modport slave (
      input  in_dat, in_val, in_sof, in_eof, in_err, in_hdr, mac_addr, out_rdy,
      output out_dat, out_val, out_sof, out_eof, out_len, out_hdr,
      output drp_err, drp_ovf, drp_flt
   );

endinterface

// File: rtl/mac_vlg_rx_ram.sv
// Simple dual-port byte RAM with registered read; the array is never reset.
module mac_vlg_rx_ram #(
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [7:0]        wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [7:0]        rdata_o
);

   logic [7:0] mem_q [2**ADDR_W];

   // Write port.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // Registered read port; output holds when no read is issued.
   always_ff @(posedge clk) begin
      if (re_i) rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/mac_vlg_rx_buf.sv
// Store-and-forward receive buffer: frames are committed only on a clean end,
// then streamed out whole from a byte RAM using a small descriptor FIFO.
module mac_vlg_rx_buf import mac_vlg_pkg::*; #(
   parameter int ADDR_W    = 11,
   parameter int DESC_W    = 2,
   parameter bit FILTER_EN = 1'b1
) (
   input logic               clk,
   input logic               rst,
   mac_vlg_rx_buf_if.slave   bus
);

   localparam int DEPTH = 2**DESC_W;

   // Write side state
   logic [ADDR_W-1:0] wrPtr_q, wrPtr_d, wrBase_q, wrBase_d;
   logic              open_q, open_d, flt_q, flt_d, ovf_q, ovf_d;
   hdr_t              hdr_q;
   logic              drpErr_q, drpErr_d, drpOvf_q, drpOvf_d, drpFlt_q, drpFlt_d;

   // Descriptor FIFO (extra pointer bit distinguishes full from empty)
   desc_t             descMem_q [DEPTH];
   logic [DESC_W:0]   descWr_q, descRd_q, descCnt;
   logic              descFull, descEmpty, push, pop;
   desc_t             pushDesc, popDesc;

   // Read side state
   rd_state_t         state_q, state_d;
   logic [ADDR_W-1:0] rdPtr_q, rdPtr_d, rem_q, rem_d, outLen_q;
   hdr_t              outHdr_q;

   // Datapath helpers
   logic              frameAct, curFlt, curOvf, wantWr, noSpace, ovfNow, ramWe, ramRe;
   logic [ADDR_W-1:0] curPtr, ptrInc, ptrAfter, lenNow;
   hdr_t              curHdr;
   logic [7:0]        ramRdata;

   assign descCnt   = descWr_q - descRd_q;
   assign descFull  = descCnt[DESC_W];
   assign descEmpty = (descWr_q == descRd_q);
   assign popDesc   = descMem_q[descRd_q[DESC_W-1:0]];

   mac_vlg_rx_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .we_i    (ramWe),
      .waddr_i (curPtr),
      .wdata_i (bus.in_dat),
      .re_i    (ramRe),
      .raddr_i (rdPtr_q),
      .rdata_o (ramRdata)
   );

   // Write side: place bytes, detect overflow, and decide commit or discard at frame end.
   always_comb begin
      frameAct = open_q || bus.in_sof;
      curPtr   = bus.in_sof ? wrBase_q : wrPtr_q;
      curFlt   = bus.in_sof ? (FILTER_EN && !dst_accepted(bus.in_hdr, bus.mac_addr)) : flt_q;
      curOvf   = bus.in_sof ? 1'b0 : ovf_q;
      curHdr   = bus.in_sof ? bus.in_hdr : hdr_q;
      ptrInc   = curPtr + ADDR_W'(1);
      noSpace  = (ptrInc == rdPtr_q);
      wantWr   = frameAct && bus.in_val && !curFlt && !curOvf;
      ramWe    = wantWr && !noSpace;
      ovfNow   = curOvf || (wantWr && noSpace);
      ptrAfter = ramWe ? ptrInc : curPtr;
      lenNow   = ptrAfter - wrBase_q;
      pushDesc = '{len: LEN_W'(lenNow), hdr: curHdr};

      wrPtr_d  = frameAct ? ptrAfter : wrPtr_q;
      wrBase_d = wrBase_q;
      open_d   = frameAct;
      flt_d    = curFlt;
      ovf_d    = ovfNow;
      push     = 1'b0;
      drpErr_d = 1'b0;
      drpOvf_d = 1'b0;
      drpFlt_d = 1'b0;

      if (frameAct && bus.in_err) begin
         wrPtr_d  = wrBase_q;
         open_d   = 1'b0;
         drpErr_d = 1'b1;
      end else if (frameAct && bus.in_eof) begin
         open_d  = 1'b0;
         wrPtr_d = wrBase_q;
         if (curFlt) begin
            drpFlt_d = 1'b1;
         end else if (ovfNow || descFull) begin
            drpOvf_d = 1'b1;
         end else if (lenNow != '0) begin
            push     = 1'b1;
            wrPtr_d  = ptrAfter;
            wrBase_d = ptrAfter;
         end
      end
   end

   // Write side registers and drop pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q  <= '0;
         wrBase_q <= '0;
         open_q   <= 1'b0;
         flt_q    <= 1'b0;
         ovf_q    <= 1'b0;
         hdr_q    <= '0;
         drpErr_q <= 1'b0;
         drpOvf_q <= 1'b0;
         drpFlt_q <= 1'b0;
      end else begin
         wrPtr_q  <= wrPtr_d;
         wrBase_q <= wrBase_d;
         open_q   <= open_d;
         flt_q    <= flt_d;
         ovf_q    <= ovf_d;
         hdr_q    <= curHdr;
         drpErr_q <= drpErr_d;
         drpOvf_q <= drpOvf_d;
         drpFlt_q <= drpFlt_d;
      end
   end

   // Descriptor storage; validity is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (push) descMem_q[descWr_q[DESC_W-1:0]] <= pushDesc;
   end

   // Read FSM next state: pop a descriptor, wait out RAM latency, then stream.
   always_comb begin
      state_d = state_q;
      rdPtr_d = rdPtr_q;
      rem_d   = rem_q;
      pop     = 1'b0;
      ramRe   = 1'b0;
      case (state_q)
         RD_IDLE: begin
            if (!descEmpty && bus.out_rdy) begin
               pop     = 1'b1;
               ramRe   = 1'b1;
               rdPtr_d = rdPtr_q + ADDR_W'(1);
               rem_d   = ADDR_W'(popDesc.len);
               state_d = RD_LOAD;
            end
         end
         RD_LOAD: state_d = RD_SEND;
         RD_SEND: begin
            rem_d = rem_q - ADDR_W'(1);
            if (rem_q == ADDR_W'(1)) begin
               state_d = RD_IDLE;
            end else begin
               ramRe   = 1'b1;
               rdPtr_d = rdPtr_q + ADDR_W'(1);
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   // Read side registers and FIFO pointers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= RD_IDLE;
         rdPtr_q  <= '0;
         rem_q    <= '0;
         outLen_q <= '0;
         outHdr_q <= '0;
         descWr_q <= '0;
         descRd_q <= '0;
      end else begin
         state_q  <= state_d;
         rdPtr_q  <= rdPtr_d;
         rem_q    <= rem_d;
         if (pop) begin
            outLen_q <= ADDR_W'(popDesc.len);
            outHdr_q <= popDesc.hdr;
            descRd_q <= descRd_q + 1'b1;
         end
         if (push) descWr_q <= descWr_q + 1'b1;
      end
   end

   assign bus.out_val = (state_q == RD_SEND);
   assign bus.out_sof = (state_q == RD_SEND) && (rem_q == outLen_q);
   assign bus.out_eof = (state_q == RD_SEND) && (rem_q == ADDR_W'(1));
   assign bus.out_dat = (state_q == RD_SEND) ? ramRdata : 8'h00;
   assign bus.out_len = outLen_q;
   assign bus.out_hdr = outHdr_q;
   assign bus.drp_err = drpErr_q;
   assign bus.drp_ovf = drpOvf_q;
   assign bus.drp_flt = drpFlt_q;

endmodule
